// File: rtl/html_tag_sequencer_if.sv
// Bus bundle for html_tag_sequencer.
// Carries the character stream (char/char_valid/char_ready), the element-parser
// side channel (parser_*), the event stream (evt_*) and the sticky error flag.
// master: the sequencer itself.  slave: the surrounding environment.
interface html_tag_sequencer_if #(
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned ATYPE_W = 4,
  parameter int unsigned AVAL_W  = 32,
  parameter int unsigned DEPTH   = 8
);
  localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;

  logic [CHAR_W-1:0]  char;
  logic               char_valid;
  logic               char_ready;
  logic               parser_enable;
  logic [CHAR_W-1:0]  parser_char;
  logic [TAG_W-1:0]   parser_tag;
  logic               parser_closing;
  logic               parser_has_attr;
  logic [ATYPE_W-1:0] parser_attr_type;
  logic [AVAL_W-1:0]  parser_attr_value;
  logic               evt_valid;
  logic               evt_ready;
  logic [1:0]         evt_kind;
  logic [TAG_W-1:0]   evt_tag;
  logic [ATYPE_W-1:0] evt_attr_type;
  logic [AVAL_W-1:0]  evt_attr_value;
  logic [CHAR_W-1:0]  evt_char;
  logic [DEPTH_W-1:0] evt_depth;
  logic               error;

  modport master (
    input  char, char_valid, parser_tag, parser_closing, parser_has_attr,
           parser_attr_type, parser_attr_value, evt_ready,
    output char_ready, parser_enable, parser_char, evt_valid, evt_kind,
           evt_tag, evt_attr_type, evt_attr_value, evt_char, evt_depth, error
  );

  modport slave (
    output char, char_valid, parser_tag, parser_closing, parser_has_attr,
           parser_attr_type, parser_attr_value, evt_ready,
    input  char_ready, parser_enable, parser_char, evt_valid, evt_kind,
           evt_tag, evt_attr_type, evt_attr_value, evt_char, evt_depth, error
  );
endinterface

// File: rtl/html_tag_sequencer.sv
// html_tag_sequencer: turns a document character stream plus element-parser
// results into OPEN/CLOSE/ATTR/TEXT events, tracking element nesting on a stack.
// Ports:
//   clock  - single clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - html_tag_sequencer_if.master (char stream in, parser side channel,
//            single-entry event slot out, sticky structural error)
module html_tag_sequencer #(
  parameter int unsigned      CHAR_W  = 8,
  parameter int unsigned      TAG_W   = 3,
  parameter int unsigned      ATYPE_W = 4,
  parameter int unsigned      AVAL_W  = 32,
  parameter int unsigned      DEPTH   = 8,
  parameter logic [TAG_W-1:0] IMG_TAG = TAG_W'(3)
) (
  input logic                  clock,
  input logic                  resetn,
  html_tag_sequencer_if.master bus
);
  localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] K_OPEN  = 2'd0;
  localparam logic [1:0] K_CLOSE = 2'd1;
  localparam logic [1:0] K_ATTR  = 2'd2;
  localparam logic [1:0] K_TEXT  = 2'd3;

  localparam logic [CHAR_W-1:0] CH_LT = CHAR_W'(8'h3C);
  localparam logic [CHAR_W-1:0] CH_GT = CHAR_W'(8'h3E);

  typedef enum logic [1:0] {ST_SCAN, ST_TAG, ST_EMIT, ST_ERR} state_t;

  state_t             r_state, w_state_nxt;
  logic [DEPTH_W-1:0] r_depth;
  logic [TAG_W-1:0]   r_stack [DEPTH];
  logic [TAG_W-1:0]   r_tag;
  logic               r_closing;
  logic               r_evt_valid;
  logic [1:0]         r_evt_kind;
  logic [TAG_W-1:0]   r_evt_tag;
  logic [ATYPE_W-1:0] r_evt_attr_type;
  logic [AVAL_W-1:0]  r_evt_attr_value;
  logic [CHAR_W-1:0]  r_evt_char;
  logic [DEPTH_W-1:0] r_evt_depth;
  logic               r_error;

  logic               w_slot_busy, w_char_ready, w_accept;
  logic [DEPTH_W-1:0] w_depth_inc, w_depth_dec;
  logic [TAG_W-1:0]   w_top;
  logic               w_load, w_latch, w_push, w_pop;
  logic [1:0]         w_kind;
  logic [TAG_W-1:0]   w_tag;
  logic [ATYPE_W-1:0] w_atype;
  logic [AVAL_W-1:0]  w_aval;
  logic [CHAR_W-1:0]  w_char;
  logic [DEPTH_W-1:0] w_edepth;

  // Slot counts as busy only if its event is not being taken this cycle.
  assign w_slot_busy  = r_evt_valid & ~bus.evt_ready;
  assign w_char_ready = ((r_state == ST_SCAN) || (r_state == ST_TAG)) && !w_slot_busy;
  assign w_accept     = bus.char_valid & w_char_ready;
  assign w_depth_inc  = r_depth + DEPTH_W'(1);
  assign w_depth_dec  = r_depth - DEPTH_W'(1);
  // Only meaningful when r_depth > 0; guarded at the use site.
  assign w_top        = r_stack[IDX_W'(w_depth_dec)];

  // Next-state and event-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_kind      = K_TEXT;
    w_tag       = '0;
    w_atype     = '0;
    w_aval      = '0;
    w_char      = '0;
    w_edepth    = '0;
    case (r_state)
      ST_SCAN: begin
        if (w_accept) begin
          if (bus.char == CH_LT) begin
            w_state_nxt = ST_TAG;
          end else begin
            w_load   = 1'b1;
            w_kind   = K_TEXT;
            w_char   = bus.char;
            w_edepth = r_depth;
          end
        end
      end
      ST_TAG: begin
        if (w_accept) begin
          if (bus.parser_has_attr) begin
            w_load   = 1'b1;
            w_kind   = K_ATTR;
            w_tag    = bus.parser_tag;
            w_atype  = bus.parser_attr_type;
            w_aval   = bus.parser_attr_value;
            w_edepth = w_depth_inc;
          end
          if (bus.char == CH_GT) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        // Decide only once the slot can take the result, so no event is lost.
        if (!w_slot_busy) begin
          if (!r_closing) begin
            if (r_tag == IMG_TAG) begin
              // Void element: reported one level deeper but never pushed.
              w_load      = 1'b1;
              w_kind      = K_OPEN;
              w_tag       = r_tag;
              w_edepth    = w_depth_inc;
              w_state_nxt = ST_SCAN;
            end else if (r_depth < DEPTH_W'(DEPTH)) begin
              w_push      = 1'b1;
              w_load      = 1'b1;
              w_kind      = K_OPEN;
              w_tag       = r_tag;
              w_edepth    = w_depth_inc;
              w_state_nxt = ST_SCAN;
            end else begin
              w_state_nxt = ST_ERR;
            end
          end else if ((r_depth != '0) && (w_top == r_tag)) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_kind      = K_CLOSE;
            w_tag       = r_tag;
            w_edepth    = r_depth;
            w_state_nxt = ST_SCAN;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      default: w_state_nxt = ST_ERR;
    endcase
  end

  // State, depth, latched tag and event slot.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state          <= ST_SCAN;
      r_depth          <= '0;
      r_tag            <= '0;
      r_closing        <= 1'b0;
      r_evt_valid      <= 1'b0;
      r_evt_kind       <= '0;
      r_evt_tag        <= '0;
      r_evt_attr_type  <= '0;
      r_evt_attr_value <= '0;
      r_evt_char       <= '0;
      r_evt_depth      <= '0;
      r_error          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_tag     <= bus.parser_tag;
        r_closing <= bus.parser_closing;
      end
      if (w_push) begin
        r_depth <= w_depth_inc;
      end else if (w_pop) begin
        r_depth <= w_depth_dec;
      end
      if (w_state_nxt == ST_ERR) begin
        r_evt_valid <= 1'b0;
        r_error     <= 1'b1;
      end else if (w_load) begin
        r_evt_valid      <= 1'b1;
        r_evt_kind       <= w_kind;
        r_evt_tag        <= w_tag;
        r_evt_attr_type  <= w_atype;
        r_evt_attr_value <= w_aval;
        r_evt_char       <= w_char;
        r_evt_depth      <= w_edepth;
      end else if (bus.evt_ready) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  // Stack storage needs no reset: depth==0 marks it empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_stack[IDX_W'(r_depth)] <= r_tag;
    end
  end

  assign bus.char_ready     = w_char_ready;
  assign bus.parser_enable  = (r_state == ST_TAG);
  assign bus.parser_char    = bus.char;
  assign bus.evt_valid      = r_evt_valid;
  assign bus.evt_kind       = r_evt_kind;
  assign bus.evt_tag        = r_evt_tag;
  assign bus.evt_attr_type  = r_evt_attr_type;
  assign bus.evt_attr_value = r_evt_attr_value;
  assign bus.evt_char       = r_evt_char;
  assign bus.evt_depth      = r_evt_depth;
  assign bus.error          = r_error;
endmodule

// File: tb/tb_html_tag_sequencer.sv
// Scoreboard bench for html_tag_sequencer: the stimulus side plays the element
// parser, predicts events from document structure and queues them; a monitor
// pops and compares each accepted event.
module tb_html_tag_sequencer;
  localparam int unsigned DEPTH = 8;
  localparam logic [2:0] DIV = 3'd1;
  localparam logic [2:0] P   = 3'd2;
  localparam logic [2:0] IMG = 3'd3;
  localparam logic [1:0] K_OPEN = 2'd0, K_CLOSE = 2'd1, K_ATTR = 2'd2, K_TEXT = 2'd3;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  html_tag_sequencer_if #(.CHAR_W(8), .TAG_W(3), .ATYPE_W(4), .AVAL_W(32), .DEPTH(DEPTH)) bus ();

  html_tag_sequencer #(.CHAR_W(8), .TAG_W(3), .ATYPE_W(4), .AVAL_W(32), .DEPTH(DEPTH),
                       .IMG_TAG(IMG)) dut (.clock(clock), .resetn(resetn), .bus(bus));

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  tag;
    logic [3:0]  atype;
    logic [31:0] aval;
    logic [7:0]  ch;
    logic [3:0]  depth;
  } ev_t;

  ev_t        exp_q[$];
  logic [2:0] m_stack[$];
  bit         m_err;
  bit         g_abort;
  int         n_checks = 0;
  int         n_pass = 0;
  int         ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic ev_t mk(input logic [1:0] k, input logic [2:0] t, input logic [3:0] at,
                             input logic [31:0] av, input logic [7:0] c, input int d);
    ev_t e;
    e.kind = k; e.tag = t; e.atype = at; e.aval = av; e.ch = c; e.depth = 4'(d);
    return e;
  endfunction

  function automatic logic [7:0] tag_char(input logic [2:0] t);
    if (t == DIV) return "d";
    if (t == P) return "p";
    return "i";
  endfunction

  // Consumer-side ready generator.
  initial begin
    bus.evt_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       bus.evt_ready = 1'b1;
        1:       bus.evt_ready = 1'($urandom_range(0, 1));
        default: bus.evt_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted event is matched against the head of the queue.
  initial begin
    forever begin
      @(negedge clock);
      if (resetn && bus.evt_valid && bus.evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got kind %0d tag %0d depth %0d, want no event",
                   bus.evt_kind, bus.evt_tag, bus.evt_depth);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("evt_kind", 64'(bus.evt_kind), 64'(e.kind));
          case (e.kind)
            K_OPEN, K_CLOSE: begin
              chk("evt_tag", 64'(bus.evt_tag), 64'(e.tag));
              chk("evt_depth", 64'(bus.evt_depth), 64'(e.depth));
            end
            K_ATTR: begin
              chk("attr_tag", 64'(bus.evt_tag), 64'(e.tag));
              chk("attr_type", 64'(bus.evt_attr_type), 64'(e.atype));
              chk("attr_value", 64'(bus.evt_attr_value), 64'(e.aval));
              chk("attr_depth", 64'(bus.evt_depth), 64'(e.depth));
            end
            default: begin
              chk("text_char", 64'(bus.evt_char), 64'(e.ch));
              chk("text_depth", 64'(bus.evt_depth), 64'(e.depth));
            end
          endcase
        end
      end
    end
  end

  task automatic send_char(input logic [7:0] c, input bit in_tag, input bit has_attr = 1'b0,
                           input logic [3:0] at = 4'd0, input logic [31:0] av = 32'd0);
    int k;
    k = 0;
    if (g_abort) return;
    bus.char = c;
    bus.char_valid = 1'b1;
    bus.parser_has_attr = has_attr;
    bus.parser_attr_type = at;
    bus.parser_attr_value = av;
    while (1) begin
      @(negedge clock);
      if (bus.char_ready) break;
      k++;
      if (k > 300) begin
        n_checks++;
        $display("FAIL char_stall: char_ready low for %0d cycles, want acceptance", k);
        g_abort = 1'b1;
        bus.char_valid = 1'b0;
        return;
      end
    end
    chk("parser_enable", 64'(bus.parser_enable), 64'(in_tag));
    chk("parser_char", 64'(bus.parser_char), 64'(c));
    @(posedge clock);
    #1;
    bus.char_valid = 1'b0;
    bus.parser_has_attr = 1'b0;
  endtask

  task automatic send_text(input logic [7:0] c);
    if (m_err || g_abort) return;
    exp_q.push_back(mk(K_TEXT, 3'd0, 4'd0, 32'd0, c, m_stack.size()));
    send_char(c, 1'b0);
  endtask

  // One whole element tag; the outcome follows the nesting rules directly.
  task automatic send_tag(input bit closing, input logic [2:0] tag, input int nattr);
    if (m_err || g_abort) return;
    bus.parser_tag = tag;
    bus.parser_closing = closing;
    send_char("<", 1'b0);
    if (closing) send_char("/", 1'b1);
    send_char(tag_char(tag), 1'b1);
    for (int i = 0; i < nattr; i++) begin
      logic [3:0]  at;
      logic [31:0] av;
      at = 4'($urandom_range(0, 15));
      av = $urandom;
      exp_q.push_back(mk(K_ATTR, tag, at, av, 8'd0, m_stack.size() + 1));
      send_char("a", 1'b1, 1'b1, at, av);
    end
    if (!closing) begin
      if (tag == IMG) exp_q.push_back(mk(K_OPEN, tag, 4'd0, 32'd0, 8'd0, m_stack.size() + 1));
      else if (m_stack.size() == DEPTH) m_err = 1'b1;
      else begin
        m_stack.push_back(tag);
        exp_q.push_back(mk(K_OPEN, tag, 4'd0, 32'd0, 8'd0, m_stack.size()));
      end
    end else if (m_stack.size() == 0 || m_stack[$] != tag) begin
      m_err = 1'b1;
    end else begin
      exp_q.push_back(mk(K_CLOSE, tag, 4'd0, 32'd0, 8'd0, m_stack.size()));
      void'(m_stack.pop_back());
    end
    send_char(">", 1'b1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.char_valid = 1'b0;
    bus.parser_has_attr = 1'b0;
    #2;
    chk("rst_evt_valid", 64'(bus.evt_valid), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_parser_enable", 64'(bus.parser_enable), 64'd0);
    chk("rst_payload", {bus.evt_kind, bus.evt_tag, bus.evt_attr_type, bus.evt_char, bus.evt_depth}, 64'd0);
    chk("rst_attr_value", 64'(bus.evt_attr_value), 64'd0);
    exp_q.delete();
    m_stack.delete();
    m_err = 1'b0;
    g_abort = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic finish_doc(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s_drain: %0d events still expected, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk({name, "_error"}, 64'(bus.error), 64'(m_err));
    chk({name, "_evt_valid_idle"}, 64'(bus.evt_valid), 64'd0);
    chk({name, "_char_ready_idle"}, 64'(bus.char_ready), 64'(!m_err));
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    bus.char = 8'd0;
    bus.char_valid = 1'b0;
    bus.parser_tag = 3'd0;
    bus.parser_closing = 1'b0;
    bus.parser_has_attr = 1'b0;
    bus.parser_attr_type = 4'd0;
    bus.parser_attr_value = 32'd0;
    #6;

    // <d>x</d> : open, text at depth 1, close, back to depth 0
    do_reset();
    ready_mode = 0;
    send_tag(1'b0, DIV, 0); send_text("x"); send_tag(1'b1, DIV, 0); send_text("y");
    finish_doc("div_text");

    // <d><p></d> : mismatch close
    do_reset();
    send_tag(1'b0, DIV, 0); send_tag(1'b0, P, 0); send_tag(1'b1, DIV, 0);
    finish_doc("mismatch");

    // </p> from reset : underflow
    do_reset();
    send_tag(1'b1, P, 0);
    finish_doc("underflow");

    // nine nested <d> : overflow after eight opens
    do_reset();
    for (int i = 0; i < 9; i++) send_tag(1'b0, DIV, 0);
    finish_doc("overflow");

    // <i> with a stalled consumer : event held, then depth still 0
    do_reset();
    ready_mode = 2;
    @(posedge clock); #1;
    send_tag(1'b0, IMG, 0);
    begin
      int k;
      k = 0;
      while (!bus.evt_valid && k < 20) begin @(negedge clock); k++; end
      for (int i = 0; i < 5; i++) begin
        @(negedge clock);
        chk("stall_valid", 64'(bus.evt_valid), 64'd1);
        chk("stall_kind_tag_depth", {bus.evt_kind, bus.evt_tag, bus.evt_depth}, {K_OPEN, IMG, 4'd1});
        chk("stall_char_ready", 64'(bus.char_ready), 64'd0);
      end
    end
    ready_mode = 0;
    send_text("z");
    finish_doc("img_stall");

    // "<d" then reset mid-tag, then <p>
    do_reset();
    bus.parser_tag = DIV;
    bus.parser_closing = 1'b0;
    send_char("<", 1'b0);
    send_char("d", 1'b1);
    do_reset();
    send_tag(1'b0, P, 0);
    finish_doc("reset_mid_tag");

    // Randomized documents with attributes and a random consumer.
    for (int d = 0; d < 24; d++) begin
      int ntok;
      do_reset();
      ready_mode = (d % 2 == 0) ? 1 : 0;
      ntok = $urandom_range(10, 30);
      for (int t = 0; t < ntok; t++) begin
        int r;
        logic [2:0] tg;
        r = $urandom_range(0, 19);
        tg = 3'($urandom_range(1, 3));
        if (r < 8) send_text(8'($urandom_range(32'h61, 32'h7a)));
        else if (r < 13) send_tag(1'b0, tg, $urandom_range(0, 2));
        else if (r < 19 && m_stack.size() != 0) send_tag(1'b1, m_stack[$], $urandom_range(0, 1));
        else if (r == 19) send_tag(1'b1, tg, 0);
        else send_text("q");
      end
      send_text("e");
      finish_doc("random_doc");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
